// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA engine: a CPU write to the DMA register copies one 256-byte page
// into the OAM data port while stalling the CPU; otherwise the CPU bus passes through.
//
// state | meaning
// IDLE  | CPU bus passed through to memory, CPU runs
// HALT  | CPU stalled, bus quiet for one cycle
// ALIGN | extra quiet cycle so every READ lands on an even cycle
// READ  | fetch byte {page_r, idx_r} into data_r
// WRITE | store data_r to the OAM data port, advance idx_r
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wen,
    input  logic        cpu_ren,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state, state_nxt;
    logic [7:0] page_r, idx_r, data_r;
    logic       par_r;
    logic       trig;

    assign trig = (state == IDLE) && cpu_wen && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            page_r <= 8'h00;
            idx_r  <= 8'h00;
            data_r <= 8'h00;
            par_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            par_r <= ~par_r;
            if (trig) begin
                page_r <= cpu_wdata;
                idx_r  <= 8'h00;
            end
            if (state == READ)
                data_r <= mem_rdata;
            if (state == WRITE)
                idx_r <= idx_r + 8'h01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = HALT;
            HALT:    state_nxt = par_r ? READ : ALIGN;
            ALIGN:   state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (idx_r == LAST_IDX) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_rdata  = 8'h00;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        case (state)
            IDLE: begin
                cpu_rdata  = mem_rdata;
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                mem_wen    = cpu_wen;
                mem_ren    = cpu_ren;
            end
            READ: begin
                mem_addr = {page_r, idx_r};
                mem_ren  = 1'b1;
            end
            WRITE: begin
                mem_addr  = OAM_DATA_ADDR;
                mem_wdata = data_r;
                mem_wen   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory holds (low address byte ^ A5h), and a
// negedge monitor tracks the read/write pairing of every transfer.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_wen = 1'b0;
    logic        cpu_ren = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    int n_checks = 0;
    int n_fail   = 0;

    oam_dma_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // every byte holds its low address bits XOR A5h
    assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

    int edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    logic [7:0]  exp_page, exp_idx;
    int          wr_cnt, seq_err, zero_hits, low_cnt;
    logic        pending, first_seen, first_par;
    logic [15:0] last_rd;
    logic [7:0]  last_wd;

    initial begin
        exp_page = 8'h00; exp_idx = 8'h00; wr_cnt = 0; seq_err = 0; zero_hits = 0;
        low_cnt = 0; pending = 1'b0; first_seen = 1'b0; first_par = 1'b0;
        last_rd = 16'h0000; last_wd = 8'h00;
    end

    always @(negedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            if (!cpu_rdy) low_cnt <= low_cnt + 1;
            if (!dma_active) begin
                if (cpu_wen && cpu_addr == 16'h4014) begin
                    exp_page   <= cpu_wdata;
                    exp_idx    <= 8'h00;
                    wr_cnt     <= 0;
                    seq_err    <= 0;
                    zero_hits  <= 0;
                    low_cnt    <= 0;
                    pending    <= 1'b0;
                    first_seen <= 1'b0;
                end else if (pending) begin
                    seq_err <= seq_err + 1;
                    pending <= 1'b0;
                end
            end else begin
                if ((mem_ren || mem_wen) && mem_addr == 16'h0000) zero_hits <= zero_hits + 1;
                if (mem_ren) begin
                    if (pending || mem_wen || mem_addr != {exp_page, exp_idx}) seq_err <= seq_err + 1;
                    pending <= 1'b1;
                    last_rd <= mem_addr;
                    if (!first_seen) begin
                        first_seen <= 1'b1;
                        first_par  <= edge_cnt[0];
                    end
                end else if (mem_wen) begin
                    if (!pending || mem_addr != 16'h2004 || mem_wdata != (exp_idx ^ 8'hA5))
                        seq_err <= seq_err + 1;
                    pending <= 1'b0;
                    exp_idx <= exp_idx + 8'h01;
                    wr_cnt  <= wr_cnt + 1;
                    last_wd <= mem_wdata;
                end else if (pending) begin
                    seq_err <= seq_err + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // par < 0: trigger on the next edge regardless of parity
    task automatic trigger(input logic [7:0] page, input int par);
        if (par >= 0 && ((edge_cnt + 1) % 2) != par) tick();
        cpu_addr  = 16'h4014;
        cpu_wdata = page;
        cpu_wen   = 1'b1;
        #1;
        check("trig_passthru_wen", 32'(mem_wen), 32'd1);
        check("trig_passthru_addr", 32'(mem_addr), 32'h4014);
        tick();
        cpu_wen = 1'b0;
        check("trig_active", 32'(dma_active), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!cpu_rdy && n < 700) begin
            tick();
            n++;
        end
        check(tag, 32'(cpu_rdy), 32'd1);
    endtask

    task automatic check_xfer(input string tag, input logic [15:0] last_addr);
        tick();
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd256);
        check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
        check({tag, "_zero_hits"}, 32'(zero_hits), 32'd0);
        check({tag, "_last_rd"}, 32'(last_rd), 32'(last_addr));
        check({tag, "_last_wd"}, 32'(last_wd), 32'h5A);
        check({tag, "_first_par"}, 32'(first_par), 32'd0);
        check({tag, "_idle_after"}, 32'(dma_active), 32'd0);
    endtask

    initial begin
        // 1: reset and pass-through
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_active", 32'(dma_active), 32'd0);
        cpu_addr = 16'h0005;
        cpu_ren  = 1'b1;
        #1;
        check("pt_addr", 32'(mem_addr), 32'h0005);
        check("pt_ren", 32'(mem_ren), 32'd1);
        check("pt_rdata", 32'(cpu_rdata), 32'hA0);
        tick();
        cpu_ren = 1'b0;

        // 2 and 3: page 02h with odd HALT, then even HALT
        trigger(8'h02, 1);
        wait_idle("odd_timeout");
        check("odd_low_cycles", 32'(low_cnt), 32'd513);
        check_xfer("odd", 16'h02FF);
        check("odd_first_wd_seq", 32'(seq_err), 32'd0);

        trigger(8'h02, 0);
        wait_idle("even_timeout");
        check("even_low_cycles", 32'(low_cnt), 32'd514);
        check_xfer("even", 16'h02FF);

        // 4: top page must not wrap to 0000h
        trigger(8'hFF, -1);
        wait_idle("pgff_timeout");
        check_xfer("pgff", 16'hFFFF);

        // 5: reset in the WRITE of idx 64h, then a fresh transfer from page 03h
        trigger(8'h02, -1);
        begin
            int n;
            n = 0;
            while (!(dma_active && mem_wen && exp_idx == 8'h64) && n < 600) begin
                tick();
                n++;
            end
            check("mid_reach_idx64", 32'(exp_idx), 32'h64);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_active", 32'(dma_active), 32'd0);
        check("mid_rst_rdy", 32'(cpu_rdy), 32'd1);
        check("mid_rst_wen", 32'(mem_wen), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        trigger(8'h03, -1);
        wait_idle("pg03_timeout");
        check_xfer("pg03", 16'h03FF);

        // 6: neighbouring registers do not trigger
        cpu_addr = 16'h4015; cpu_wdata = 8'h33; cpu_wen = 1'b1;
        #1;
        check("w4015_addr", 32'(mem_addr), 32'h4015);
        check("w4015_wdata", 32'(mem_wdata), 32'h33);
        tick();
        check("w4015_no_trig", 32'(dma_active), 32'd0);
        cpu_addr = 16'h4016; cpu_wdata = 8'h01;
        #1;
        check("w4016_wen", 32'(mem_wen), 32'd1);
        tick();
        check("w4016_no_trig", 32'(dma_active), 32'd0);
        cpu_wen = 1'b0; cpu_addr = 16'h2002; cpu_ren = 1'b1;
        #1;
        check("r2002_ren", 32'(mem_ren), 32'd1);
        check("r2002_rdata", 32'(cpu_rdata), 32'hA7);
        tick();
        check("r2002_no_trig", 32'(dma_active), 32'd0);
        cpu_ren = 1'b0;

        // 6: rewrite of the DMA register during a transfer is ignored
        trigger(8'h02, -1);
        repeat (10) tick();
        cpu_addr = 16'h4014; cpu_wdata = 8'h07; cpu_wen = 1'b1; cpu_ren = 1'b1;
        #1;
        check("busy_rdata_zero", 32'(cpu_rdata), 32'h00);
        check("busy_rdy_low", 32'(cpu_rdy), 32'd0);
        check("busy_no_passthru", 32'(mem_addr == 16'h4014), 32'd0);
        repeat (20) tick();
        cpu_wen = 1'b0; cpu_ren = 1'b0; cpu_addr = 16'h0000;
        wait_idle("force_timeout");
        check_xfer("force", 16'h02FF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
